// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared FSM encoding, defaults and hazard helper for pipe_ctrl
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_LD_BUBBLE = 2'd1,
    ST_MC_WAIT   = 2'd2
  } state_t;

  localparam int MC_TIMEOUT_DEF = 64;

  // A load whose rd (non-x0) feeds either source of the decode instruction.
  function automatic logic lu_hazard(
    input logic       is_load,
    input logic       reg_wen,
    input logic [4:0] rd,
    input logic [4:0] rs1,
    input logic [4:0] rs2
  );
    return is_load && reg_wen && (rd != 5'd0) && ((rd == rs1) || (rd == rs2));
  endfunction

endpackage

// File: rtl/pipe_ctrl_perf.sv
// rtl/pipe_ctrl_perf.sv - wrapping event counters for pipe_ctrl (PIPE_CTRL_PERF_EN builds)
module pipe_ctrl_perf #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_ev,
  input  logic             bubble_ev,
  input  logic             flush_ev,
  input  logic             timeout_ev,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] bubble_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] timeout_cnt
);

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt   <= '0;
      bubble_cnt  <= '0;
      flush_cnt   <= '0;
      timeout_cnt <= '0;
    end else begin
      if (stall_ev)   stall_cnt   <= stall_cnt + 1'b1;
      if (bubble_ev)  bubble_cnt  <= bubble_cnt + 1'b1;
      if (flush_ev)   flush_cnt   <= flush_cnt + 1'b1;
      if (timeout_ev) timeout_cnt <= timeout_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - stall/flush/redirect controller for the 5-stage RV32I pipeline
// Optional perf counters and ports are built when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MC_TIMEOUT = MC_TIMEOUT_DEF,
  parameter int CNT_W      = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs1_addr_i,
  input  logic [4:0]  id_rs2_addr_i,
  input  logic [4:0]  ex_rd_addr_i,
  input  logic        ex_reg_wen_i,
  input  logic        ex_is_load_i,
  input  logic        ex_jump_en_i,
  input  logic [31:0] ex_jump_addr_i,
  input  logic        ex_mc_start_i,
  input  logic        ex_mc_done_i,
  output logic        jump_en_o,
  output logic [31:0] jump_addr_o,
  output logic        stall_pc_o,
  output logic        stall_if_id_o,
  output logic        stall_id_ex_o,
  output logic        flush_if_id_o,
  output logic        flush_id_ex_o,
  output logic        mc_timeout_o,
`ifdef PIPE_CTRL_PERF_EN
  output logic [CNT_W-1:0] perf_stall_o,
  output logic [CNT_W-1:0] perf_bubble_o,
  output logic [CNT_W-1:0] perf_flush_o,
  output logic [CNT_W-1:0] perf_timeout_o,
`endif
  output logic        err_o
);

  if (MC_TIMEOUT < 2 || MC_TIMEOUT > 65535 || CNT_W < 1) begin : g_bad_param
    $error("pipe_ctrl: MC_TIMEOUT must be 2..65535 and CNT_W >= 1");
  end

  localparam logic [15:0] MC_LAST = 16'(MC_TIMEOUT - 1);

  state_t      state, state_nxt;
  logic [15:0] mc_cnt;
  logic        err_q;
  logic        lu;

  assign lu = lu_hazard(ex_is_load_i, ex_reg_wen_i, ex_rd_addr_i, id_rs1_addr_i, id_rs2_addr_i);

  always_comb begin
    state_nxt     = state;
    jump_en_o     = 1'b0;
    jump_addr_o   = 32'd0;
    stall_pc_o    = 1'b0;
    stall_if_id_o = 1'b0;
    stall_id_ex_o = 1'b0;
    flush_if_id_o = 1'b0;
    flush_id_ex_o = 1'b0;
    mc_timeout_o  = 1'b0;
    case (state)
      ST_RUN, ST_LD_BUBBLE: begin
        state_nxt = ST_RUN;
        if (ex_jump_en_i) begin
          jump_en_o     = 1'b1;
          jump_addr_o   = ex_jump_addr_i;
          flush_if_id_o = 1'b1;
          flush_id_ex_o = 1'b1;
        end else if (ex_mc_start_i) begin
          stall_pc_o    = 1'b1;
          stall_if_id_o = 1'b1;
          stall_id_ex_o = 1'b1;
          state_nxt     = ST_MC_WAIT;
        end else if (lu && state == ST_RUN) begin
          // LU is masked in LD_BUBBLE so one load costs exactly one bubble.
          stall_pc_o    = 1'b1;
          stall_if_id_o = 1'b1;
          flush_id_ex_o = 1'b1;
          state_nxt     = ST_LD_BUBBLE;
        end
      end
      ST_MC_WAIT: begin
        if (ex_mc_done_i) begin
          state_nxt = ST_RUN;
        end else if (mc_cnt == MC_LAST) begin
          mc_timeout_o  = 1'b1;
          flush_id_ex_o = 1'b1;
          state_nxt     = ST_RUN;
        end else begin
          stall_pc_o    = 1'b1;
          stall_if_id_o = 1'b1;
          stall_id_ex_o = 1'b1;
        end
      end
      default: state_nxt = ST_RUN;
    endcase
    // Outputs read as zero for the whole reset cycle, whatever the inputs do.
    if (rst) begin
      jump_en_o     = 1'b0;
      jump_addr_o   = 32'd0;
      stall_pc_o    = 1'b0;
      stall_if_id_o = 1'b0;
      stall_id_ex_o = 1'b0;
      flush_if_id_o = 1'b0;
      flush_id_ex_o = 1'b0;
      mc_timeout_o  = 1'b0;
    end
  end

  assign err_o = err_q & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_RUN;
      mc_cnt <= 16'd0;
      err_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state != ST_MC_WAIT)  mc_cnt <= 16'd0;
      else if (mc_cnt != '1)    mc_cnt <= mc_cnt + 16'd1;
      if (mc_timeout_o)         err_q  <= 1'b1;
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  pipe_ctrl_perf #(.CNT_W(CNT_W)) u_perf (
    .clk         (clk),
    .rst         (rst),
    .stall_ev    (stall_pc_o),
    .bubble_ev   (stall_pc_o & flush_id_ex_o),
    .flush_ev    (flush_if_id_o | flush_id_ex_o),
    .timeout_ev  (mc_timeout_o),
    .stall_cnt   (perf_stall_o),
    .bubble_cnt  (perf_bubble_o),
    .flush_cnt   (perf_flush_o),
    .timeout_cnt (perf_timeout_o)
  );
`endif

endmodule
